// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between two requesters:
//     m0 = pipeline MEM stage, m1 = debug/loader port.
//   Grants are round-robin and decided combinationally, so the access happens
//   in the grant cycle. Read data comes back registered one cycle later.
//   A clear sequencer zero-fills the whole memory on clr_req, one word per
//   cycle, and blocks all grants while it runs.
//   This block is the only driver of the memory ports.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   clr_req             pulse that starts the zero-fill
//   clr_busy            high while the zero-fill runs
//   mX_req/we/addr/wdata  requester X access; req is held until mX_gnt
//   mX_gnt              combinational grant; the access happens this cycle
//   mX_rvalid           one-cycle pulse in the cycle after a granted read
//   mX_rdata            registered read data; holds its value between reads
//   mem_r_enable, mem_w_enable, mem_address, mem_wr_data  to data_mem
//   mem_re_data         combinational read data from data_mem
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_LSB = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_r_enable,
  output logic          mem_w_enable,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_re_data
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t        state_q, state_d;
  // last_q: 0 = m0 was granted most recently, 1 = m1
  logic          last_q, last_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic          m0_rvalid_q, m0_rvalid_d;
  logic          m1_rvalid_q, m1_rvalid_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;

  logic          gnt0, gnt1;
  logic          rd0, rd1;

  // Grant decision. Outputs are forced low while reset is held so that
  // nothing reaches the memory during reset, even with requests pending.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b1 & 1'b0;
    if (!rst && (state_q == ST_ARB)) begin
      if (m0_req && (!m1_req || last_q)) begin
        gnt0 = 1'b1;
      end else if (m1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign rd0 = gnt0 & ~m0_we;
  assign rd1 = gnt1 & ~m1_we;

  // Memory port drive: the granted master in ARB, the zero-fill in CLEAR.
  always_comb begin
    mem_r_enable = 1'b0;
    mem_w_enable = 1'b0;
    mem_address  = '0;
    mem_wr_data  = '0;
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_w_enable = 1'b1;
        mem_address  = AW'(clr_cnt_q) << ADDR_LSB;
      end else if (gnt0) begin
        mem_w_enable = m0_we;
        mem_r_enable = ~m0_we;
        mem_address  = m0_addr;
        mem_wr_data  = m0_wdata;
      end else if (gnt1) begin
        mem_w_enable = m1_we;
        mem_r_enable = ~m1_we;
        mem_address  = m1_addr;
        mem_wr_data  = m1_wdata;
      end
    end
  end

  // Next state, round-robin pointer and clear counter.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_ARB: begin
        // A grant in the same cycle as clr_req still completes; the clear
        // only takes over the memory from the next cycle.
        if (clr_req) state_d = ST_CLEAR;
        if (gnt0) begin
          last_d = 1'b0;
        end else if (gnt1) begin
          last_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == CW'(DEPTH - 1)) begin
          state_d   = ST_ARB;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = ST_ARB;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Read return: capture memory data at the grant edge, data holds otherwise.
  always_comb begin
    m0_rvalid_d = rd0;
    m1_rvalid_d = rd1;
    m0_rdata_d  = rd0 ? mem_re_data : m0_rdata_q;
    m1_rdata_d  = rd1 ? mem_re_data : m1_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ARB;
      last_q      <= 1'b1;
      clr_cnt_q   <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      clr_cnt_q   <= clr_cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign clr_busy  = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Bench for dmem_arbiter with a behavioural 32-word data memory attached.
//   Directed scenarios followed by a randomized phase, all compared against a
//   reference model of the arbitration, read return and clear rules.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_req, clr_busy;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_r_enable, mem_w_enable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wr_data, mem_re_data;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .ADDR_LSB(2)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(clr_busy),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_r_enable(mem_r_enable), .mem_w_enable(mem_w_enable),
    .mem_address(mem_address), .mem_wr_data(mem_wr_data),
    .mem_re_data(mem_re_data)
  );

  // Behavioural data memory: combinational read, posedge write, low bits ignored.
  logic [DW-1:0] dmem [DEPTH];
  logic          load_mem = 1'b0;
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < DEPTH; i++) dmem[i] <= DW'(i);
    end else if (mem_w_enable) begin
      dmem[mem_address[6:2]] <= mem_wr_data;
    end
  end
  assign mem_re_data = mem_r_enable ? dmem[mem_address[6:2]] : '0;

  // Reference model state
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mm [DEPTH];
  bit            m_last;      // 1: m1 won last (m0 wins next tie)
  bit            m_busy;
  int            m_cnt;
  logic [DW-1:0] hd0, hd1;    // expected held read data
  bit            g0, g1;      // model grants of the latest step
  bit            dg0, dg1;    // DUT grants sampled in the latest step
  int            waited;
  bit            r0, w0, r1, w1, clr;
  logic [31:0]   a0, d0, a1, d1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut(input bit load);
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    clr_req = 0;
    load_mem = load;
    #1;
    chk("rst_gnt", {m0_gnt, m1_gnt}, 2'b00);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    chk("rst_rdata0", m0_rdata, 0);
    chk("rst_rdata1", m1_rdata, 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_mem_en", {mem_r_enable, mem_w_enable}, 2'b00);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_mem_wdata", mem_wr_data, 0);
    @(posedge clk); #1;
    load_mem = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_last = 1; m_busy = 0; m_cnt = 0; hd0 = '0; hd1 = '0;
    if (load) for (int i = 0; i < DEPTH; i++) mm[i] = DW'(i);
  endtask

  // One clock cycle: drive inputs, check combinational outputs against the
  // model, advance the model, then check the registered read return.
  task automatic step(input bit rq0, input bit we0, input logic [31:0] ad0, input logic [31:0] wd0,
                      input bit rq1, input bit we1, input logic [31:0] ad1, input logic [31:0] wd1,
                      input bit cl);
    bit            ew, er, nv0, nv1;
    logic [31:0]   ea, ed;
    m0_req = rq0; m0_we = we0; m0_addr = ad0; m0_wdata = wd0;
    m1_req = rq1; m1_we = we1; m1_addr = ad1; m1_wdata = wd1;
    clr_req = cl;
    #1;
    g0 = 0; g1 = 0; ew = 0; er = 0; ea = '0; ed = '0;
    if (m_busy) begin
      ew = 1; ea = 32'(m_cnt) << 2;
    end else begin
      if (rq0 && rq1) begin
        if (m_last) g0 = 1; else g1 = 1;
      end else begin
        g0 = rq0; g1 = rq1;
      end
      if (g0) begin ew = we0; er = !we0; ea = ad0; ed = wd0; end
      if (g1) begin ew = we1; er = !we1; ea = ad1; ed = wd1; end
    end
    dg0 = m0_gnt; dg1 = m1_gnt;
    chk("gnt0", m0_gnt, g0);
    chk("gnt1", m1_gnt, g1);
    chk("busy", clr_busy, m_busy);
    chk("mem_we", mem_w_enable, ew);
    chk("mem_re", mem_r_enable, er);
    chk("mem_addr", mem_address, ea);
    chk("mem_wdata", mem_wr_data, ed);
    nv0 = g0 && !we0;
    nv1 = g1 && !we1;
    if (m_busy) begin
      mm[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) begin m_busy = 0; m_cnt = 0; end
    end else begin
      if (g0) begin
        m_last = 0;
        if (we0) mm[ad0[6:2]] = wd0; else hd0 = mm[ad0[6:2]];
      end
      if (g1) begin
        m_last = 1;
        if (we1) mm[ad1[6:2]] = wd1; else hd1 = mm[ad1[6:2]];
      end
      if (cl) m_busy = 1;
    end
    @(posedge clk); #1;
    chk("rvalid0", m0_rvalid, nv0);
    chk("rvalid1", m1_rvalid, nv1);
    chk("rdata0", m0_rdata, hd0);
    chk("rdata1", m1_rdata, hd1);
  endtask

  initial begin
    rst = 1'b0;
    #2;
    reset_dut(1);

    // 1: m0 read 0x08 on fresh memory
    step(1, 0, 32'h08, 0, 0, 0, 0, 0, 0);
    chk("t1_gnt", dg0, 1);
    chk("t1_rdata", m0_rdata, 2);

    // 2: m0 write 0x10, then m1 reads it back
    step(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'h10, 0, 0);
    chk("t2_rdata", m1_rdata, 32'hDEADBEEF);

    // 3: both request for 4 cycles after reset -> m0,m1,m0,m1
    reset_dut(1);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 32'h0C, 0, 1, 0, 32'h14, 0, 0);
      chk("t3_gnt0", dg0, (k % 2) == 0);
      chk("t3_gnt1", dg1, (k % 2) == 1);
    end

    // 4: clear pulse; m0 read of 0x7C waits for the whole clear
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    waited = 0;
    g0 = 0;
    while (!g0 && waited <= 40) begin
      step(1, 0, 32'h7C, 0, 0, 0, 0, 0, 0);
      if (!g0) waited++;
    end
    chk("t4_wait", waited, 32);
    chk("t4_rdata", m0_rdata, 0);
    for (int i = 0; i < DEPTH; i++) chk("t4_mem", dmem[i], mm[i]);

    // 5: clr_req with m1 read 0x04 in the same cycle
    reset_dut(1);
    step(0, 0, 0, 0, 1, 0, 32'h04, 0, 1);
    chk("t5_gnt", dg1, 1);
    chk("t5_rdata", m1_rdata, 1);
    for (int k = 1; k < 10; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_busy", clr_busy, 1);

    // 6: reset at clear cycle 10, then m0 read 0x00 granted at once
    rst = 1'b1;
    m0_req = 1;
    #1;
    chk("t6_busy", clr_busy, 0);
    chk("t6_gnt_in_rst", m0_gnt, 0);
    reset_dut(0);
    step(1, 0, 32'h00, 0, 0, 0, 0, 0, 0);
    chk("t6_gnt", dg0, 1);
    chk("t6_rdata", m0_rdata, 0);

    // Randomized traffic with held requests and occasional clears
    reset_dut(1);
    r0 = 0; r1 = 0; w0 = 0; w1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int n = 0; n < 400; n++) begin
      if (!r0 || g0) begin
        r0 = $urandom_range(0, 1); w0 = $urandom_range(0, 1);
        a0 = $urandom(); d0 = $urandom();
      end
      if (!r1 || g1) begin
        r1 = $urandom_range(0, 1); w1 = $urandom_range(0, 1);
        a1 = $urandom(); d1 = $urandom();
      end
      clr = ($urandom_range(0, 59) == 0);
      step(r0, w0, a0, d0, r1, w1, a1, d1, clr);
    end
    for (int i = 0; i < DEPTH; i++) chk("rand_mem", dmem[i], mm[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
